dtc_preimage_enum: RTL and testbench

//  Inverse companion to the decision-tree classifiers: given a target class, enumerates every input vector
//  the classifier maps to that class and streams each one out over a valid/ready handshake.
//  A classifier instance sits beside this block at the top level: it takes cand_o and returns cls_i combinationally.

---
 rtl/dtc_pkg.sv | 21 ++
 rtl/dtc_out_reg.sv | 48 ++++
 rtl/dtc_preimage_enum.sv | 125 ++++++++++++
 tb/tb_dtc_preimage_enum.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dtc_pkg
//  Brief    : Shared types and widths for the decision-tree preimage enumerator
//  Revision : 1.0 - initial release
// ============================================================================
package dtc_pkg;

  localparam int DTC_IN_W  = 8;
  localparam int DTC_OUT_W = 2;

  // Control states of the enumerator
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dtc_state_e;

endpackage : dtc_pkg
`default_nettype wire

// File: rtl/dtc_out_reg.sv
`default_nettype none
// ============================================================================
//  Module   : dtc_out_reg
//  Brief    : One-entry valid/ready holding register with load, accept, flush
//  Revision : 1.0 - initial release
// ============================================================================
module dtc_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] din_i,
  input  logic         ready_i,
  input  logic         flush_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         accept_o,
  output logic         free_o
);

  logic [W-1:0] r_data;
  logic         r_valid;

  // Flush drops the entry; a load may replace an entry being accepted this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (load_i) begin
      r_data  <= din_i;
      r_valid <= 1'b1;
    end else if (r_valid && ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign data_o   = r_data;
  assign valid_o  = r_valid;
  // A flushed entry is never reported as consumed
  assign accept_o = r_valid & ready_i & ~flush_i;
  // Slot can take a new vector when empty or being drained this cycle
  assign free_o   = ~r_valid | ready_i;

endmodule : dtc_out_reg
`default_nettype wire

// File: rtl/dtc_preimage_enum.sv
`default_nettype none
// ============================================================================
//  Module   : dtc_preimage_enum
//  Brief    : Enumerates every classifier input that maps to a target class and
//             streams the matches out over valid/ready
//  Revision : 1.0 - initial release
// ============================================================================
module dtc_preimage_enum
  import dtc_pkg::*;
#(
  parameter int IN_W  = DTC_IN_W,
  parameter int OUT_W = DTC_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [OUT_W-1:0] target_i,
  output logic [IN_W-1:0]  cand_o,
  input  logic [OUT_W-1:0] cls_i,
  output logic [IN_W-1:0]  vec_o,
  output logic             vec_valid_o,
  input  logic             vec_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [IN_W:0]    match_cnt_o
);

  dtc_state_e       r_state;
  dtc_state_e       w_state_nxt;
  logic [OUT_W-1:0] r_target;
  logic [IN_W-1:0]  r_cand;
  logic [IN_W:0]    r_match_cnt;

  logic w_start;
  logic w_flush;
  logic w_match;
  logic w_last;
  logic w_free;
  logic w_advance;
  logic w_load;
  logic w_accept;

  assign w_start = (r_state == ST_IDLE) && start_i;
  assign w_flush = (r_state != ST_IDLE) && abort_i;
  assign w_match = (cls_i == r_target);
  assign w_last  = &r_cand;

  // Next-state and per-cycle scan decisions
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_free) begin
          w_advance = 1'b1;
          w_load    = w_match;
          if (w_last) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort_i)     w_state_nxt = ST_IDLE;
        else if (w_free) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Target latch and candidate counter; the counter parks at all-ones at the end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= '0;
      r_cand   <= '0;
    end else if (w_start) begin
      r_target <= target_i;
      r_cand   <= '0;
    end else if (w_advance && !w_last) begin
      r_cand   <= r_cand + IN_W'(1);
    end
  end

  // Accepted-vector counter; held across abort and idle, cleared on a new scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_match_cnt <= '0;
    else if (w_start)  r_match_cnt <= '0;
    else if (w_accept) r_match_cnt <= r_match_cnt + (IN_W+1)'(1);
  end

  dtc_out_reg #(
    .W (IN_W)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (w_load),
    .din_i    (r_cand),
    .ready_i  (vec_ready_i),
    .flush_i  (w_flush),
    .data_o   (vec_o),
    .valid_o  (vec_valid_o),
    .accept_o (w_accept),
    .free_o   (w_free)
  );

  assign cand_o      = r_cand;
  assign busy_o      = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
  assign done_o      = (r_state == ST_DONE);
  assign match_cnt_o = r_match_cnt;

endmodule : dtc_preimage_enum
`default_nettype wire

// File: tb/tb_dtc_preimage_enum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dtc_preimage_enum
//  Brief    : Self-checking bench for the preimage enumerator with a stub
//             classifier and a preimage-list reference model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dtc_preimage_enum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [1:0] target_i = 2'b00;
  logic [7:0] cand_o;
  logic [1:0] cls_i;
  logic [7:0] vec_o;
  logic       vec_valid_o;
  logic       vec_ready_i = 1'b1;
  logic       busy_o;
  logic       done_o;
  logic [8:0] match_cnt_o;

  int stub_mode = 0;

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of every input whose class equals the target
  int exp_q[$];

  bit         en_chk = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_vec = '0;
  logic [7:0] prev_cand = '0;
  int         acc_cnt = 0;
  int         done_cnt = 0;
  int         busy_cyc = 0;
  int         valid_cyc = 0;

  dtc_preimage_enum dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .target_i    (target_i),
    .cand_o      (cand_o),
    .cls_i       (cls_i),
    .vec_o       (vec_o),
    .vec_valid_o (vec_valid_o),
    .vec_ready_i (vec_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .match_cnt_o (match_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] stub_cls(input int mode, input logic [7:0] c);
    case (mode)
      0:       return c[1:0];
      1:       return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

  assign cls_i = stub_cls(stub_mode, cand_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic build_model(input logic [1:0] tgt);
    exp_q.delete();
    for (int k = 0; k < 256; k++) begin
      logic [7:0] kv;
      kv = k[7:0];
      if (stub_cls(stub_mode, kv) == tgt) exp_q.push_back(k);
    end
  endtask

  // Issue a start; afterwards we sit 1 time unit past the edge that accepted it
  task automatic start_scan(input logic [1:0] tgt);
    @(posedge clk); #1;
    busy_cyc  = 0;
    valid_cyc = 0;
    target_i  = tgt;
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    acc_cnt = 0;
    chk("start_cand", 32'(cand_o), 32'd0);
    chk("start_busy", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_cand(input int v, input string name);
    int n;
    n = 0;
    while (cand_o !== v[7:0] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (cand_o !== v[7:0]) fail_now(name);
  endtask

  task automatic wait_done(input string name, input int d0, input int exp_cnt);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_o !== 1'b1) fail_now({name, "_done_timeout"});
    chk({name, "_match_cnt"}, 32'(match_cnt_o), 32'(exp_cnt));
    chk({name, "_model_left"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_done_low"}, 32'(done_o), 32'd0);
    chk({name, "_busy_low"}, 32'(busy_o), 32'd0);
  endtask

  // Per-cycle compare against the model and the handshake rules
  always @(negedge clk) begin
    if (!en_chk || !rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (busy_o)      busy_cyc++;
      if (vec_valid_o) valid_cyc++;
      if (done_o)      done_cnt++;
      chk("match_cnt_track", 32'(match_cnt_o), 32'(acc_cnt));
      if (prev_hold) begin
        chk("hold_valid", 32'(vec_valid_o), 32'd1);
        chk("hold_vec", 32'(vec_o), 32'(prev_vec));
        chk("hold_cand", 32'(cand_o), 32'(prev_cand));
      end
      if (vec_valid_o && vec_ready_i && !abort_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_vec: got %0d expected none", vec_o);
        end else begin
          chk("vec_order", 32'(vec_o), 32'(exp_q.pop_front()));
        end
        acc_cnt++;
      end
      prev_hold = vec_valid_o && !vec_ready_i && !abort_i;
      prev_vec  = vec_o;
      prev_cand = cand_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cand", 32'(cand_o), 32'd0);
    chk("rst_vec", 32'(vec_o), 32'd0);
    chk("rst_valid", 32'(vec_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_cnt", 32'(match_cnt_o), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    en_chk = 1'b1;

    // Target 01, no backpressure: 1,5,...,253; start during SCAN ignored
    stub_mode   = 0;
    vec_ready_i = 1'b1;
    build_model(2'b01);
    d0 = done_cnt;
    start_scan(2'b01);
    @(posedge clk); #1;
    chk("lat_no_valid_yet", 32'(vec_valid_o), 32'd0);
    @(posedge clk); #1;
    chk("lat_first_valid", 32'(vec_valid_o), 32'd1);
    chk("lat_first_vec", 32'(vec_o), 32'd1);
    wait_cand(50, "t1_wait50");
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("start_ignored_cand", 32'(cand_o), 32'd51);
    wait_done("t1", d0, 64);

    // Same with a 10-cycle stall on the third vector
    build_model(2'b01);
    d0 = done_cnt;
    start_scan(2'b01);
    n = 0;
    while (!(vec_valid_o === 1'b1 && vec_o === 8'd9) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(vec_valid_o === 1'b1 && vec_o === 8'd9)) fail_now("t2_wait9");
    vec_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_cand", 32'(cand_o), 32'd10);
      chk("stall_vec", 32'(vec_o), 32'd9);
    end
    vec_ready_i = 1'b1;
    wait_done("t2", d0, 64);

    // No class ever matches: 256 SCAN cycles plus one DRAIN cycle busy
    stub_mode = 1;
    build_model(2'b11);
    d0 = done_cnt;
    start_scan(2'b11);
    wait_done("t3", d0, 0);
    chk("t3_busy_cycles", 32'(busy_cyc), 32'd257);
    chk("t3_valid_cycles", 32'(valid_cyc), 32'd0);

    // Every input matches: 256 back-to-back vectors
    stub_mode = 2;
    build_model(2'b10);
    d0 = done_cnt;
    start_scan(2'b10);
    wait_done("t4", d0, 256);
    chk("t4_busy_cycles", 32'(busy_cyc), 32'd257);
    chk("t4_valid_cycles", 32'(valid_cyc), 32'd256);
    chk("t4_cnt_literal", 32'(match_cnt_o), 32'h100);

    // Abort at candidate 100 with vector 99 pending and ready high
    stub_mode = 0;
    build_model(2'b11);
    d0 = done_cnt;
    start_scan(2'b11);
    wait_cand(100, "t5_wait100");
    chk("abort_pending_valid", 32'(vec_valid_o), 32'd1);
    chk("abort_pending_vec", 32'(vec_o), 32'd99);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("abort_valid", 32'(vec_valid_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_cnt", 32'(match_cnt_o), 32'd24);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_cnt_held", 32'(match_cnt_o), 32'd24);
    build_model(2'b11);
    d0 = done_cnt;
    start_scan(2'b11);
    wait_done("t5_restart", d0, 64);

    // Asynchronous reset mid-scan, then a fresh scan
    build_model(2'b01);
    start_scan(2'b01);
    wait_cand(30, "t6_wait30");
    #2;
    en_chk = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("arst_cand", 32'(cand_o), 32'd0);
    chk("arst_vec", 32'(vec_o), 32'd0);
    chk("arst_valid", 32'(vec_valid_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_cnt", 32'(match_cnt_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acc_cnt = 0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("arst_idle_busy", 32'(busy_o), 32'd0);
    chk("arst_idle_cand", 32'(cand_o), 32'd0);
    en_chk = 1'b1;
    build_model(2'b01);
    d0 = done_cnt;
    start_scan(2'b01);
    wait_done("t6", d0, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dtc_preimage_enum
`default_nettype wire
